// File: rtl/cache_victim_ctrl_pkg.sv
// Shared types for the miss-side victim controller.
//   victim_state_t : controller FSM states
//   way_idx_width  : width of a way index for a given associativity
package cache_victim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_REFILL    = 3'd3,
    ST_DONE      = 3'd4
  } victim_state_t;

  function automatic int unsigned way_idx_width(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_victim_ctrl_first_invalid_way.sv
// Priority encoder: lowest-numbered way whose valid bit is clear.
//   valid : per-way valid bits
//   found : at least one invalid way exists
//   index : lowest invalid way (0 when found=0)
module cache_victim_ctrl_first_invalid_way #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [WAYS-1:0]  valid,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan high to low so the lowest invalid way wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cache_victim_ctrl.sv
// Miss-side victim controller: per accepted miss, picks a victim way, writes it back
// when dirty, requests the refill, then reports the way to the replacement generator.
//   miss_*        : miss request handshake (tag/index of the missing line)
//   tag_rd_*      : tag RAM read strobe (combinational, in the accept cycle)
//   way_*         : set contents, valid the cycle after tag_rd_en
//   repl_*        : replacement generator index in, access/update feedback out
//   wb_*          : write-back request/address/ack
//   refill_*      : refill request/address/ack
//   done          : one-cycle completion pulse, victim_way valid with it
module cache_victim_ctrl
  import cache_victim_ctrl_pkg::*;
#(
  parameter int unsigned SET_ASSOC    = 4,
  parameter int unsigned TAG_WIDTH    = 20,
  parameter int unsigned INDEX_WIDTH  = 6,
  parameter int unsigned OFFSET_WIDTH = 6
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         miss_valid,
  output logic                                         miss_ready,
  input  logic [TAG_WIDTH-1:0]                         miss_tag,
  input  logic [INDEX_WIDTH-1:0]                       miss_index,
  output logic                                         tag_rd_en,
  output logic [INDEX_WIDTH-1:0]                       tag_rd_index,
  input  logic [SET_ASSOC-1:0]                         way_valid,
  input  logic [SET_ASSOC-1:0]                         way_dirty,
  input  logic [SET_ASSOC*TAG_WIDTH-1:0]               way_tag,
  input  logic [$clog2(SET_ASSOC)-1:0]                 repl_index,
  output logic [SET_ASSOC-1:0]                         repl_access,
  output logic                                         repl_update,
  output logic                                         wb_req,
  output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] wb_addr,
  input  logic                                         wb_ack,
  output logic                                         refill_req,
  output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] refill_addr,
  input  logic                                         refill_ack,
  output logic                                         done,
  output logic [$clog2(SET_ASSOC)-1:0]                 victim_way
);

  localparam int unsigned WAY_W = way_idx_width(SET_ASSOC);

  victim_state_t          state_q, state_nxt;
  logic [INDEX_WIDTH-1:0] index_q;
  logic                   accept;
  logic                   inv_found;
  logic [WAY_W-1:0]       inv_idx;
  logic [WAY_W-1:0]       victim_sel;
  logic                   sel_dirty;
  logic [TAG_WIDTH-1:0]   sel_tag;

  // Accept and tag read happen in the same IDLE cycle.
  assign accept       = (state_q == ST_IDLE) && miss_valid;
  assign tag_rd_en    = accept;
  assign tag_rd_index = miss_index;

  cache_victim_ctrl_first_invalid_way #(
    .WAYS  (SET_ASSOC),
    .IDX_W (WAY_W)
  ) u_first_invalid (
    .valid (way_valid),
    .found (inv_found),
    .index (inv_idx)
  );

  // Victim choice: an empty way beats the generator's pick.
  assign victim_sel = inv_found ? inv_idx : repl_index;
  assign sel_dirty  = way_valid[victim_sel] && way_dirty[victim_sel];
  assign sel_tag    = way_tag[int'(victim_sel) * TAG_WIDTH +: TAG_WIDTH];

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_nxt = ST_SELECT;
      ST_SELECT:    state_nxt = sel_dirty ? ST_WRITEBACK : ST_REFILL;
      ST_WRITEBACK: if (wb_ack) state_nxt = ST_REFILL;
      ST_REFILL:    if (refill_ack) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath registers and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      miss_ready  <= 1'b1;
      wb_req      <= 1'b0;
      refill_req  <= 1'b0;
      done        <= 1'b0;
      repl_update <= 1'b0;
      repl_access <= '0;
      victim_way  <= '0;
      index_q     <= '0;
      wb_addr     <= '0;
      refill_addr <= '0;
    end else begin
      state_q     <= state_nxt;
      miss_ready  <= (state_nxt == ST_IDLE);
      wb_req      <= (state_nxt == ST_WRITEBACK);
      refill_req  <= (state_nxt == ST_REFILL);
      done        <= (state_nxt == ST_DONE);
      repl_update <= (state_nxt == ST_DONE);
      repl_access <= (state_nxt == ST_DONE)
                     ? ({{(SET_ASSOC-1){1'b0}}, 1'b1} << victim_way) : '0;
      if (accept) begin
        index_q     <= miss_index;
        refill_addr <= {miss_tag, miss_index, {OFFSET_WIDTH{1'b0}}};
      end
      if (state_q == ST_SELECT) begin
        victim_way <= victim_sel;
        wb_addr    <= {sel_tag, index_q, {OFFSET_WIDTH{1'b0}}};
      end
    end
  end

endmodule

// File: tb/tb_cache_victim_ctrl.sv
// Self-checking bench for cache_victim_ctrl: directed table, multi-cycle corner
// sequences and randomized misses against a trace-level reference model.
module tb_cache_victim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_valid = 1'b0;
  logic        miss_ready;
  logic [19:0] miss_tag = '0;
  logic [5:0]  miss_index = '0;
  logic        tag_rd_en;
  logic [5:0]  tag_rd_index;
  logic [3:0]  way_valid = '0;
  logic [3:0]  way_dirty = '0;
  logic [79:0] way_tag = '0;
  logic [1:0]  repl_index = '0;
  logic [3:0]  repl_access;
  logic        repl_update;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic        wb_ack = 1'b0;
  logic        refill_req;
  logic [31:0] refill_addr;
  logic        refill_ack = 1'b0;
  logic        done;
  logic [1:0]  victim_way;

  always #5 clk = ~clk;

  cache_victim_ctrl #(
    .SET_ASSOC(4), .TAG_WIDTH(20), .INDEX_WIDTH(6), .OFFSET_WIDTH(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_tag(miss_tag), .miss_index(miss_index),
    .tag_rd_en(tag_rd_en), .tag_rd_index(tag_rd_index),
    .way_valid(way_valid), .way_dirty(way_dirty), .way_tag(way_tag),
    .repl_index(repl_index), .repl_access(repl_access), .repl_update(repl_update),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .refill_req(refill_req), .refill_addr(refill_addr), .refill_ack(refill_ack),
    .done(done), .victim_way(victim_way)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  dirty;
    logic [79:0] tags;
    logic [1:0]  repl;
    logic [19:0] tag;
    logic [5:0]  idx;
    int          wd;       // extra write-back cycles before wb_ack
    int          rd;       // extra refill cycles before refill_ack
    logic [1:0]  exp_victim;
    bit          exp_wb;
    logic [31:0] exp_wb_addr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first invalid way, otherwise the generator's choice.
  function automatic logic [1:0] ref_victim(input logic [3:0] valid, input logic [1:0] repl);
    for (int i = 0; i < 4; i++) if (!valid[i]) return 2'(i);
    return repl;
  endfunction

  function automatic logic [19:0] tag_of(input logic [79:0] tags, input logic [1:0] w);
    return tags[int'(w) * 20 +: 20];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_miss_ready"}, 32'(miss_ready), 32'd1);
    chk({tag, "_wb_req"}, 32'(wb_req), 32'd0);
    chk({tag, "_refill_req"}, 32'(refill_req), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_repl_update"}, 32'(repl_update), 32'd0);
    chk({tag, "_repl_access"}, 32'(repl_access), 32'd0);
  endtask

  task automatic chk_reset_regs(input string tag);
    chk_idle(tag);
    chk({tag, "_victim_way"}, 32'(victim_way), 32'd0);
    chk({tag, "_wb_addr"}, wb_addr, 32'd0);
    chk({tag, "_refill_addr"}, refill_addr, 32'd0);
    chk({tag, "_tag_rd_en"}, 32'(tag_rd_en), 32'd0);
  endtask

  // One complete miss. Entered and left just after a rising edge with the DUT idle.
  task automatic run_miss(input vec_t v, input logic [1:0] ev, input bit ewb,
                          input logic [31:0] ewa, input bit hold);
    int ph[$];
    int wc = 0;
    int rc = 0;
    logic [31:0] erf;
    erf = {v.tag, v.idx, 6'b0};
    miss_valid = 1'b1;
    miss_tag   = v.tag;
    miss_index = v.idx;
    way_valid  = 4'($urandom);   // tag RAM data not yet valid in the accept cycle
    way_dirty  = 4'($urandom);
    way_tag    = {$urandom, $urandom, 16'($urandom)};
    repl_index = 2'($urandom);
    #1;
    chk("accept_miss_ready", 32'(miss_ready), 32'd1);
    for (int w = 0; w < 8 && !miss_ready; w++) begin @(posedge clk); #1; end
    chk("accept_tag_rd_en", 32'(tag_rd_en), 32'd1);
    chk("accept_tag_rd_index", 32'(tag_rd_index), 32'(v.idx));
    @(posedge clk); #1;
    if (!hold) miss_valid = 1'b0;
    // Expected cycle trace: 1=select 2=writeback 3=refill 4=done
    ph.push_back(1);
    if (ewb) repeat (v.wd + 1) ph.push_back(2);
    repeat (v.rd + 1) ph.push_back(3);
    ph.push_back(4);
    foreach (ph[k]) begin
      way_valid  = v.valid;
      way_dirty  = v.dirty;
      way_tag    = v.tags;
      repl_index = v.repl;
      if (ph[k] == 2) begin wb_ack = (wc == v.wd); wc++; end
      else wb_ack = ($urandom_range(0, 2) == 0);
      if (ph[k] == 3) begin refill_ack = (rc == v.rd); rc++; end
      else refill_ack = ($urandom_range(0, 2) == 0);
      #1;
      chk("miss_ready_busy", 32'(miss_ready), 32'd0);
      chk("tag_rd_en_busy", 32'(tag_rd_en), 32'd0);
      chk("wb_req", 32'(wb_req), 32'(ph[k] == 2));
      chk("refill_req", 32'(refill_req), 32'(ph[k] == 3));
      chk("done", 32'(done), 32'(ph[k] == 4));
      chk("repl_update", 32'(repl_update), 32'(ph[k] == 4));
      chk("repl_access", 32'(repl_access), (ph[k] == 4) ? (32'd1 << ev) : 32'd0);
      if (ph[k] == 2) chk("wb_addr", wb_addr, ewa);
      if (ph[k] == 3) chk("refill_addr", refill_addr, erf);
      if (ph[k] == 4) chk("victim_way", 32'(victim_way), 32'(ev));
      @(posedge clk); #1;
    end
    wb_ack     = 1'b0;
    refill_ack = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [1:0] ev;

    tbl[0] = '{4'b1011, 4'hF, {20'h33333, 20'h44444, 20'h55555, 20'h66666}, 2'd3,
               20'h12345, 6'h2A, 0, 0, 2'd2, 1'b0, 32'h0};
    tbl[1] = '{4'hF, 4'b0100, {20'h00000, 20'hABCDE, 20'h11111, 20'h22222}, 2'd2,
               20'h0F0F0, 6'd5, 3, 1, 2'd2, 1'b1, 32'hABCDE140};
    tbl[2] = '{4'hF, 4'h0, {20'h77777, 20'h88888, 20'h99999, 20'hAAAAA}, 2'd1,
               20'hFEDCB, 6'h11, 0, 2, 2'd1, 1'b0, 32'h0};
    tbl[3] = '{4'h0, 4'hF, {20'h1, 20'h2, 20'h3, 20'h4}, 2'd3,
               20'h00001, 6'h00, 0, 0, 2'd0, 1'b0, 32'h0};
    tbl[4] = '{4'b0111, 4'hF, {20'h5, 20'h6, 20'h7, 20'h8}, 2'd0,
               20'h80000, 6'h3F, 0, 1, 2'd3, 1'b0, 32'h0};
    tbl[5] = '{4'hF, 4'hF, {20'hFFFFF, 20'h00001, 20'h00002, 20'h12345}, 2'd0,
               20'hCAFE0, 6'h3F, 0, 0, 2'd0, 1'b1, 32'h12345FC0};

    // Reset state, observed while reset is still asserted.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_regs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_regs("post_reset");

    // Directed table.
    foreach (tbl[i]) run_miss(tbl[i], tbl[i].exp_victim, tbl[i].exp_wb, tbl[i].exp_wb_addr, 1'b0);

    // miss_valid held through DONE: next miss accepted the cycle after done.
    run_miss(tbl[0], tbl[0].exp_victim, tbl[0].exp_wb, tbl[0].exp_wb_addr, 1'b1);
    run_miss(tbl[5], tbl[5].exp_victim, tbl[5].exp_wb, tbl[5].exp_wb_addr, 1'b1);
    run_miss(tbl[2], tbl[2].exp_victim, tbl[2].exp_wb, tbl[2].exp_wb_addr, 1'b0);

    // Stray acks while idle do nothing.
    wb_ack = 1'b1; refill_ack = 1'b1;
    @(posedge clk); #1;
    chk_idle("idle_stray");
    wb_ack = 1'b0; refill_ack = 1'b0;
    @(posedge clk); #1;
    chk_idle("idle_stray2");

    // Reset while write-back is pending, then a late wb_ack.
    v = tbl[1];
    v.wd = 10;
    miss_valid = 1'b1; miss_tag = v.tag; miss_index = v.idx;
    @(posedge clk); #1;
    miss_valid = 1'b0;
    way_valid = v.valid; way_dirty = v.dirty; way_tag = v.tags; repl_index = v.repl;
    @(posedge clk); #1;
    chk("rst_pre_wb_req", 32'(wb_req), 32'd1);
    @(posedge clk); #1;
    chk("rst_pre_wb_req2", 32'(wb_req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset_regs("rst_mid");
    wb_ack = 1'b1; refill_ack = 1'b1;
    @(posedge clk); #1;
    wb_ack = 1'b0; refill_ack = 1'b0;
    chk_reset_regs("rst_late_ack");
    @(posedge clk); #1;
    chk_reset_regs("rst_late_ack2");
    run_miss(tbl[1], tbl[1].exp_victim, tbl[1].exp_wb, tbl[1].exp_wb_addr, 1'b0);

    // Randomized misses against the reference model.
    for (int n = 0; n < 150; n++) begin
      v.valid = 4'($urandom);
      if ($urandom_range(0, 1) == 0) v.valid = 4'hF;
      v.dirty = 4'($urandom);
      v.tags  = {$urandom, $urandom, 16'($urandom)};
      v.repl  = 2'($urandom);
      v.tag   = 20'($urandom);
      v.idx   = 6'($urandom);
      v.wd    = $urandom_range(0, 3);
      v.rd    = $urandom_range(0, 3);
      ev = ref_victim(v.valid, v.repl);
      run_miss(v, ev, v.valid[ev] && v.dirty[ev], {tag_of(v.tags, ev), v.idx, 6'b0},
               ($urandom_range(0, 3) == 0) && (n != 149));
    end
    miss_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
